// File: rtl/ifsram_wr_ctrl_pkg.sv
// Shared definitions for the ifmap SRAM write controller: state encoding,
// buffer geometry and the skip-mask column search.
package ifsram_wr_ctrl_pkg;

   localparam int NUM_BUFS = 8;
   localparam int COL_BITS = 3;
   localparam int CH_BITS  = 5;
   localparam int ROW_BITS = 3;

   // Buffers 0, 1, 6 and 7 are owned by the padding writer while it runs.
   localparam logic [NUM_BUFS-1:0] PAD_BUF_MASK = 8'b1100_0011;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_PAD_REQ  = 3'd2,
      ST_PAD_WAIT = 3'd3,
      ST_DONE     = 3'd4
   } wr_state_e;

   typedef struct packed {
      logic                found;
      logic [COL_BITS-1:0] idx;
   } col_hit_t;

   // Lowest buffer index >= from whose skip bit is clear.
   function automatic col_hit_t find_col(input logic [NUM_BUFS-1:0] mask,
                                         input logic [COL_BITS:0]   from);
      col_hit_t hit;
      hit = '0;
      for (int b = NUM_BUFS - 1; b >= 0; b--) begin
         if (b >= int'(from) && !mask[b]) begin
            hit.found = 1'b1;
            hit.idx   = COL_BITS'(b);
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/ifsram_wr_ctrl_if.sv
// Stream input and shared SRAM write bundle of the ifmap write controller.
interface ifsram_wr_ctrl_if
   import ifsram_wr_ctrl_pkg::*;
#(
   parameter int TBITS   = 64,
   parameter int ADDBITS = 11
);

   logic                        din_valid;
   logic [TBITS-1:0]            din_data;
   logic                        din_ready;

   logic [NUM_BUFS-1:0]         ifb_cen;
   logic [NUM_BUFS-1:0]         ifb_wen;
   logic [NUM_BUFS*ADDBITS-1:0] ifb_addr;
   logic [TBITS-1:0]            ifb_data;

   modport master (
      input  din_valid, din_data,
      output din_ready,
      output ifb_cen, ifb_wen, ifb_addr, ifb_data
   );

   modport slave (
      output din_valid, din_data,
      input  din_ready,
      input  ifb_cen, ifb_wen, ifb_addr, ifb_data
   );

endinterface

// File: rtl/ifsram_col_seq.sv
// Load-order sequencer: walks channel word, unmasked column and row, giving
// the target buffer, SRAM address and last-word flag of the next stream word.
module ifsram_col_seq
   import ifsram_wr_ctrl_pkg::*;
#(
   parameter int ADDBITS = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [NUM_BUFS-1:0] start_mask,
   input  logic                advance,
   input  logic [CH_BITS-1:0]  atlchin,
   input  logic [ROW_BITS-1:0] rows,
   input  logic [ADDBITS-1:0]  row_stride,
   input  logic [NUM_BUFS-1:0] skip_mask,
   output logic [COL_BITS-1:0] col,
   output logic [ADDBITS-1:0]  addr,
   output logic                last,
   output logic                all_skipped
);

   logic [CH_BITS-1:0]  ch_q;
   logic [COL_BITS-1:0] col_q;
   logic [ROW_BITS-1:0] row_q;
   logic [ADDBITS-1:0]  base_q;

   col_hit_t next_hit;
   col_hit_t first_hit;
   col_hit_t start_hit;
   logic     ch_last;
   logic     row_last;

   assign next_hit  = find_col(skip_mask, {1'b0, col_q} + 4'd1);
   assign first_hit = find_col(skip_mask, 4'd0);
   assign start_hit = find_col(start_mask, 4'd0);

   assign ch_last     = (ch_q == atlchin - 5'd1);
   assign row_last    = ch_last && !next_hit.found;
   assign last        = row_last && (row_q == rows);
   assign all_skipped = &skip_mask;

   assign col  = col_q;
   assign addr = base_q + ADDBITS'(ch_q);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ch_q   <= '0;
         col_q  <= '0;
         row_q  <= '0;
         base_q <= '0;
      end else if (start) begin
         ch_q   <= '0;
         col_q  <= start_hit.idx;
         row_q  <= '0;
         base_q <= '0;
      end else if (advance) begin
         if (!ch_last) begin
            ch_q <= ch_q + 5'd1;
         end else begin
            ch_q <= '0;
            if (next_hit.found) begin
               col_q <= next_hit.idx;
            end else begin
               // Row wrap: back to the first loaded column, base steps by one stride.
               col_q  <= first_hit.idx;
               row_q  <= row_q + 3'd1;
               base_q <= base_q + row_stride;
            end
         end
      end
   end

endmodule

// File: rtl/ifsram_wr_ctrl.sv
// Ifmap SRAM write controller: loads the DMA word stream into buffers 0-7,
// then hands buffers 0/1/6/7 to the padding writer until it reports done.
module ifsram_wr_ctrl
   import ifsram_wr_ctrl_pkg::*;
#(
   parameter int TBITS              = 64,
   parameter int IFMAP_SRAM_ADDBITS = 11
) (
   input  logic                          clk,
   input  logic                          reset,

   input  logic                          wr_start,
   input  logic [CH_BITS-1:0]            cfg_atlchin,
   input  logic [ROW_BITS-1:0]           cfg_rows,
   input  logic [IFMAP_SRAM_ADDBITS-1:0] cfg_row_stride,
   input  logic [NUM_BUFS-1:0]           cfg_skip_mask,
   input  logic                          cfg_pad_en,

   output logic                          wr_busy,
   output logic                          wr_done,
   output logic                          if_pad_start,
   input  logic                          if_pad_done,

   input  logic                          pdb0_cen,
   input  logic                          pdb1_cen,
   input  logic                          pdb6_cen,
   input  logic                          pdb7_cen,
   input  logic                          pdb0_wen,
   input  logic                          pdb1_wen,
   input  logic                          pdb6_wen,
   input  logic                          pdb7_wen,
   input  logic [IFMAP_SRAM_ADDBITS-1:0] pdb0_addr,
   input  logic [IFMAP_SRAM_ADDBITS-1:0] pdb1_addr,
   input  logic [IFMAP_SRAM_ADDBITS-1:0] pdb6_addr,
   input  logic [IFMAP_SRAM_ADDBITS-1:0] pdb7_addr,
   input  logic [TBITS-1:0]              pd_data,

   ifsram_wr_ctrl_if.master              bus
);

   localparam int AB = IFMAP_SRAM_ADDBITS;

   wr_state_e state_q;
   wr_state_e state_d;

   logic [CH_BITS-1:0]  atlchin_q;
   logic [ROW_BITS-1:0] rows_q;
   logic [AB-1:0]       stride_q;
   logic [NUM_BUFS-1:0] mask_q;
   logic                pad_en_q;

   logic                start_ok;
   logic                accept;
   logic [COL_BITS-1:0] seq_col;
   logic [AB-1:0]       seq_addr;
   logic                seq_last;
   logic                all_skipped;

   logic                ld_vld_q;
   logic [COL_BITS-1:0] ld_col_q;
   logic [AB-1:0]       ld_addr_q;
   logic [TBITS-1:0]    ld_data_q;

   logic [NUM_BUFS-1:0]    cen_c;
   logic [NUM_BUFS-1:0]    wen_c;
   logic [NUM_BUFS*AB-1:0] addr_c;
   logic [TBITS-1:0]       data_c;

   assign start_ok      = wr_start && (state_q == ST_IDLE);
   assign bus.din_ready = (state_q == ST_LOAD) && !all_skipped;
   assign accept        = bus.din_valid && bus.din_ready;

   ifsram_col_seq #(
      .ADDBITS (AB)
   ) u_col_seq (
      .clk         (clk),
      .reset       (reset),
      .start       (start_ok),
      .start_mask  (cfg_skip_mask),
      .advance     (accept),
      .atlchin     (atlchin_q),
      .rows        (rows_q),
      .row_stride  (stride_q),
      .skip_mask   (mask_q),
      .col         (seq_col),
      .addr        (seq_addr),
      .last        (seq_last),
      .all_skipped (all_skipped)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every always_comb output gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (wr_start) state_d = ST_LOAD;
         ST_LOAD:     if (all_skipped || (accept && seq_last))
                         state_d = pad_en_q ? ST_PAD_REQ : ST_DONE;
         ST_PAD_REQ:  state_d = ST_PAD_WAIT;
         ST_PAD_WAIT: if (if_pad_done) state_d = ST_DONE;
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Config is frozen for the whole job; starts while busy never reach here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         atlchin_q <= '0;
         rows_q    <= '0;
         stride_q  <= '0;
         mask_q    <= '0;
         pad_en_q  <= 1'b0;
      end else if (start_ok) begin
         atlchin_q <= cfg_atlchin;
         rows_q    <= cfg_rows;
         stride_q  <= cfg_row_stride;
         mask_q    <= cfg_skip_mask;
         pad_en_q  <= cfg_pad_en;
      end
   end

   // One-cycle write stage: a word accepted at an edge is driven for the next cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_vld_q  <= 1'b0;
         ld_col_q  <= '0;
         ld_addr_q <= '0;
         ld_data_q <= '0;
      end else begin
         ld_vld_q <= accept;
         if (accept) begin
            ld_col_q  <= seq_col;
            ld_addr_q <= seq_addr;
            ld_data_q <= bus.din_data;
         end
      end
   end

   always_comb begin
      cen_c  = '1;
      wen_c  = '1;
      addr_c = '0;
      data_c = ld_data_q;
      if (state_q == ST_PAD_WAIT) begin
         // Padding writer owns buffers 0/1/6/7; buffers 2-5 stay idle.
         data_c = pd_data;
         cen_c[0] = pdb0_cen;
         cen_c[1] = pdb1_cen;
         cen_c[6] = pdb6_cen;
         cen_c[7] = pdb7_cen;
         wen_c[0] = pdb0_wen;
         wen_c[1] = pdb1_wen;
         wen_c[6] = pdb6_wen;
         wen_c[7] = pdb7_wen;
         addr_c[0*AB +: AB] = pdb0_addr;
         addr_c[1*AB +: AB] = pdb1_addr;
         addr_c[6*AB +: AB] = pdb6_addr;
         addr_c[7*AB +: AB] = pdb7_addr;
      end else if (ld_vld_q) begin
         cen_c[ld_col_q] = 1'b0;
         wen_c[ld_col_q] = 1'b0;
         addr_c[int'(ld_col_q)*AB +: AB] = ld_addr_q;
      end
   end

   assign bus.ifb_cen  = cen_c;
   assign bus.ifb_wen  = wen_c;
   assign bus.ifb_addr = addr_c;
   assign bus.ifb_data = data_c;

   assign wr_busy      = (state_q != ST_IDLE);
   assign wr_done      = (state_q == ST_DONE);
   assign if_pad_start = (state_q == ST_PAD_REQ);

endmodule

// File: tb/tb_ifsram_wr_ctrl.sv
// Randomized bench for ifsram_wr_ctrl: a job-level reference model predicts every
// output each cycle; directed jobs pin the model with hand-computed values.
module tb_ifsram_wr_ctrl;

   localparam int TB = 64;
   localparam int AB = 11;

   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_REQ  = 2;
   localparam int P_WAIT = 3;
   localparam int P_DONE = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic          wr_start = 1'b0;
   logic [4:0]    cfg_atlchin = 5'd1;
   logic [2:0]    cfg_rows = 3'd0;
   logic [AB-1:0] cfg_row_stride = '0;
   logic [7:0]    cfg_skip_mask = 8'h00;
   logic          cfg_pad_en = 1'b0;
   logic          wr_busy, wr_done, if_pad_start;
   logic          if_pad_done = 1'b0;
   logic          pdb0_cen = 1'b1, pdb1_cen = 1'b1, pdb6_cen = 1'b1, pdb7_cen = 1'b1;
   logic          pdb0_wen = 1'b1, pdb1_wen = 1'b1, pdb6_wen = 1'b1, pdb7_wen = 1'b1;
   logic [AB-1:0] pdb0_addr = '0, pdb1_addr = '0, pdb6_addr = '0, pdb7_addr = '0;
   logic [TB-1:0] pd_data = '0;

   ifsram_wr_ctrl_if #(.TBITS(TB), .ADDBITS(AB)) bus ();

   initial begin
      bus.din_valid = 1'b0;
      bus.din_data  = '0;
   end

   ifsram_wr_ctrl #(
      .TBITS              (TB),
      .IFMAP_SRAM_ADDBITS (AB)
   ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .wr_start       (wr_start),
      .cfg_atlchin    (cfg_atlchin),
      .cfg_rows       (cfg_rows),
      .cfg_row_stride (cfg_row_stride),
      .cfg_skip_mask  (cfg_skip_mask),
      .cfg_pad_en     (cfg_pad_en),
      .wr_busy        (wr_busy),
      .wr_done        (wr_done),
      .if_pad_start   (if_pad_start),
      .if_pad_done    (if_pad_done),
      .pdb0_cen       (pdb0_cen),
      .pdb1_cen       (pdb1_cen),
      .pdb6_cen       (pdb6_cen),
      .pdb7_cen       (pdb7_cen),
      .pdb0_wen       (pdb0_wen),
      .pdb1_wen       (pdb1_wen),
      .pdb6_wen       (pdb6_wen),
      .pdb7_wen       (pdb7_wen),
      .pdb0_addr      (pdb0_addr),
      .pdb1_addr      (pdb1_addr),
      .pdb6_addr      (pdb6_addr),
      .pdb7_addr      (pdb7_addr),
      .pd_data        (pd_data),
      .bus            (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int            bidx;
      logic [AB-1:0] addr;
   } wr_t;

   wr_t           m_list[$];
   int            m_phase = P_IDLE;
   int            m_idx = 0;
   bit            m_pad_en = 1'b0;
   bit            m_wr = 1'b0;
   int            m_wr_buf = 0;
   logic [AB-1:0] m_wr_addr = '0;
   logic [TB-1:0] m_wr_data = '0;
   int            cyc = 0;

   task automatic m_reset();
      m_phase = P_IDLE;
      m_wr    = 1'b0;
      m_idx   = 0;
   endtask

   // Writes in stream order: row, then ascending loaded buffer, then channel word.
   task automatic m_build(input int atl, input int rows, input int stride, input logic [7:0] mask);
      m_list.delete();
      for (int r = 0; r <= rows; r++)
         for (int b = 0; b < 8; b++)
            if (!mask[b])
               for (int c = 0; c < atl; c++) begin
                  wr_t w;
                  w.bidx = b;
                  w.addr = AB'(r * stride + c);
                  m_list.push_back(w);
               end
   endtask

   task automatic model_edge();
      m_wr = 1'b0;
      case (m_phase)
         P_IDLE: if (wr_start) begin
            m_build(int'(cfg_atlchin), int'(cfg_rows), int'(cfg_row_stride), cfg_skip_mask);
            m_pad_en = cfg_pad_en;
            m_idx    = 0;
            m_phase  = P_LOAD;
         end
         P_LOAD: begin
            if (m_list.size() == 0) begin
               m_phase = m_pad_en ? P_REQ : P_DONE;
            end else if (bus.din_valid) begin
               m_wr      = 1'b1;
               m_wr_buf  = m_list[m_idx].bidx;
               m_wr_addr = m_list[m_idx].addr;
               m_wr_data = bus.din_data;
               m_idx++;
               if (m_idx == m_list.size()) m_phase = m_pad_en ? P_REQ : P_DONE;
            end
         end
         P_REQ:  m_phase = P_WAIT;
         P_WAIT: if (if_pad_done) m_phase = P_DONE;
         P_DONE: m_phase = P_IDLE;
         default: m_phase = P_IDLE;
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      if (reset) model_edge();
      #1;
   endtask

   // ---------------- observation counters ----------------
   int            obs_wr, obs_wr67, done_cnt, pst_cnt, hit14;
   int            done_cyc, pst_cyc, start_cyc;
   int            first_bidx;
   logic [AB-1:0] first_addr;

   task automatic clear_obs();
      obs_wr = 0; obs_wr67 = 0; done_cnt = 0; pst_cnt = 0; hit14 = 0;
      done_cyc = -1; pst_cyc = -1; first_bidx = -1; first_addr = '1;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin : cmp
      logic [7:0] e_cen;
      e_cen = 8'hFF;
      check("din_ready", 64'(bus.din_ready), 64'(m_phase == P_LOAD && m_idx < m_list.size()));
      check("wr_busy", 64'(wr_busy), 64'(m_phase != P_IDLE));
      check("wr_done", 64'(wr_done), 64'(m_phase == P_DONE));
      check("if_pad_start", 64'(if_pad_start), 64'(m_phase == P_REQ));
      if (m_phase == P_WAIT) begin
         e_cen = {pdb7_cen, pdb6_cen, 4'hF, pdb1_cen, pdb0_cen};
         check("pad_wen", 64'(bus.ifb_wen), 64'({pdb7_wen, pdb6_wen, 4'hF, pdb1_wen, pdb0_wen}));
         check("pad_addr0", 64'(bus.ifb_addr[0*AB +: AB]), 64'(pdb0_addr));
         check("pad_addr1", 64'(bus.ifb_addr[1*AB +: AB]), 64'(pdb1_addr));
         check("pad_addr6", 64'(bus.ifb_addr[6*AB +: AB]), 64'(pdb6_addr));
         check("pad_addr7", 64'(bus.ifb_addr[7*AB +: AB]), 64'(pdb7_addr));
         check("pad_data", bus.ifb_data, pd_data);
      end else begin
         if (m_wr) begin
            e_cen[m_wr_buf] = 1'b0;
            check("ld_addr", 64'(bus.ifb_addr[m_wr_buf*AB +: AB]), 64'(m_wr_addr));
            check("ld_data", bus.ifb_data, m_wr_data);
         end
         check("ifb_wen", 64'(bus.ifb_wen), 64'(e_cen));
         if (bus.ifb_cen != 8'hFF) begin
            if (obs_wr == 0) begin
               for (int b = 7; b >= 0; b--)
                  if (!bus.ifb_cen[b]) begin
                     first_bidx = b;
                     first_addr = bus.ifb_addr[b*AB +: AB];
                  end
            end
            obs_wr++;
            if (bus.ifb_cen[7:6] != 2'b11) obs_wr67++;
            if (!bus.ifb_cen[3] && bus.ifb_addr[3*AB +: AB] == AB'(14)) hit14++;
         end
      end
      check("ifb_cen", 64'(bus.ifb_cen), 64'(e_cen));
      if (wr_done) begin done_cnt++; done_cyc = cyc; end
      if (if_pad_start) begin pst_cnt++; pst_cyc = cyc; end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cen"}, 64'(bus.ifb_cen), 64'(8'hFF));
      check({tag, "_wen"}, 64'(bus.ifb_wen), 64'(8'hFF));
      check({tag, "_addr"}, 64'(bus.ifb_addr), 64'd0);
      check({tag, "_data"}, bus.ifb_data, 64'd0);
      check({tag, "_ready"}, 64'(bus.din_ready), 64'd0);
      check({tag, "_busy"}, 64'(wr_busy), 64'd0);
      check({tag, "_pst"}, 64'(if_pad_start), 64'd0);
   endtask

   // ---------------- job driver ----------------
   task automatic run_job(input int atl, input int rows, input int stride, input int mask,
                          input bit pad_en, input int vmode, input int pdelay, input int reset_at);
      int wait_cnt;
      bit finished;
      wait_cnt = 0;
      finished = 1'b0;
      clear_obs();
      cfg_atlchin    = 5'(atl);
      cfg_rows       = 3'(rows);
      cfg_row_stride = AB'(stride);
      cfg_skip_mask  = 8'(mask);
      cfg_pad_en     = pad_en;
      wr_start       = 1'b1;
      start_cyc      = cyc;
      step();
      wr_start = 1'b0;
      // Scramble config inputs: the controller must use the latched values.
      cfg_atlchin    = 5'($urandom_range(1, 31));
      cfg_rows       = 3'($urandom);
      cfg_row_stride = AB'($urandom);
      cfg_skip_mask  = 8'($urandom);
      cfg_pad_en     = 1'($urandom);
      for (int k = 0; k < 4000; k++) begin
         if (m_phase == P_IDLE) begin
            finished = 1'b1;
            break;
         end
         bus.din_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(k % 2) : 1'($urandom_range(0, 1));
         bus.din_data  = {$urandom, $urandom};
         if_pad_done   = (m_phase == P_REQ);
         wr_start      = 1'b0;
         if (m_phase == P_WAIT) begin
            {pdb0_cen, pdb1_cen, pdb6_cen, pdb7_cen} = 4'($urandom);
            {pdb0_wen, pdb1_wen, pdb6_wen, pdb7_wen} = 4'($urandom);
            pdb0_addr   = AB'($urandom);
            pdb1_addr   = AB'($urandom);
            pdb6_addr   = AB'($urandom);
            pdb7_addr   = AB'($urandom);
            pd_data     = {$urandom, $urandom};
            wr_start    = (wait_cnt == 0);
            if_pad_done = (wait_cnt == pdelay);
            wait_cnt++;
         end
         step();
         if (reset_at > 0 && m_wr && m_idx == reset_at) begin
            reset = 1'b0;
            m_reset();
            #1;
            check_reset_outputs("midrst");
            step();
            step();
            reset = 1'b1;
            finished = 1'b1;
            break;
         end
      end
      bus.din_valid = 1'b0;
      if_pad_done   = 1'b0;
      wr_start      = 1'b0;
      {pdb0_cen, pdb1_cen, pdb6_cen, pdb7_cen} = 4'hF;
      {pdb0_wen, pdb1_wen, pdb6_wen, pdb7_wen} = 4'hF;
      check("job_finished", 64'(finished), 64'd1);
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      clear_obs();
      #3;
      check_reset_outputs("rst");
      step();
      step();
      #1 reset = 1'b1;
      step();

      // Basic load: 3 rows x 8 buffers x 4 words.
      run_job(4, 2, 12, 'h00, 1'b0, 0, 0, 0);
      check("basic_list_size", 64'(m_list.size()), 64'd96);
      check("basic_w46_buf", 64'(m_list[46].bidx), 64'd3);
      check("basic_w46_addr", 64'(m_list[46].addr), 64'd14);
      check("basic_writes", 64'(obs_wr), 64'd96);
      check("basic_hit14", 64'(hit14), 64'd1);
      check("basic_done_cnt", 64'(done_cnt), 64'd1);
      check("basic_done_lat", 64'(done_cyc - start_cyc), 64'd97);

      // Right-pad: buffers 6/7 skipped, padding writer runs afterwards.
      run_job(4, 2, 12, 'hC0, 1'b1, 0, 3, 0);
      check("rpad_list_size", 64'(m_list.size()), 64'd72);
      check("rpad_writes", 64'(obs_wr), 64'd72);
      check("rpad_writes67", 64'(obs_wr67), 64'd0);
      check("rpad_pst_cnt", 64'(pst_cnt), 64'd1);
      check("rpad_pst_lat", 64'(pst_cyc - start_cyc), 64'd73);
      check("rpad_done_lat", 64'(done_cyc - pst_cyc), 64'd5);
      check("rpad_done_cnt", 64'(done_cnt), 64'd1);

      // Back-pressure: valid toggles every cycle.
      run_job(4, 2, 12, 'h00, 1'b0, 1, 0, 0);
      check("bp_writes", 64'(obs_wr), 64'd96);
      check("bp_done_lat", 64'(done_cyc - start_cyc), 64'd193);

      // All columns skipped.
      run_job(4, 2, 12, 'hFF, 1'b1, 0, 2, 0);
      check("skip_writes", 64'(obs_wr), 64'd0);
      check("skip_pst_lat", 64'(pst_cyc - start_cyc), 64'd2);
      run_job(4, 2, 12, 'hFF, 1'b0, 0, 0, 0);
      check("skip_done_lat", 64'(done_cyc - start_cyc), 64'd2);

      // Reset at the 10th accepted word, then restart.
      run_job(4, 2, 12, 'h00, 1'b0, 0, 0, 10);
      run_job(4, 2, 12, 'h00, 1'b0, 2, 0, 0);
      check("restart_first_buf", 64'(first_bidx), 64'd0);
      check("restart_first_addr", 64'(first_addr), 64'd0);
      check("restart_writes", 64'(obs_wr), 64'd96);

      // Randomized jobs, including wrapping strides and arbitrary masks.
      for (int j = 0; j < 12; j++) begin
         int mask;
         mask = (j == 5) ? 'hFF : int'($urandom_range(0, 255));
         run_job(int'($urandom_range(1, 5)), int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)),
                 mask, 1'($urandom), 2, int'($urandom_range(0, 4)), 0);
         check("rand_writes", 64'(obs_wr), 64'(m_list.size()));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
